// File: rtl/jtdsp16_cache_ctrl_if.sv
// Bus bundle between the DSP16 sequencer/decoder and the loop cache controller.
// The master drives the loop commands and ROM word; the slave returns the cache outputs.
interface jtdsp16_cache_ctrl_if #(
    parameter int KW = 7
);
    logic          do_start;
    logic          redo_start;
    logic [3:0]    ni;
    logic [KW-1:0] k;
    logic [15:0]   rom_dout;
    logic [15:0]   cache_dout;
    logic          cache_sel;
    logic          pc_hold;
    logic          busy;
    logic          irq_mask;
    logic [KW-1:0] rem_cnt;

    modport master (
        output do_start, redo_start, ni, k, rom_dout,
        input  cache_dout, cache_sel, pc_hold, busy, irq_mask, rem_cnt
    );

    modport slave (
        input  do_start, redo_start, ni, k, rom_dout,
        output cache_dout, cache_sel, pc_hold, busy, irq_mask, rem_cnt
    );
endinterface

// File: rtl/jtdsp16_cache_ctrl.sv
// DO/REDO loop cache sequencer: captures a loop body from ROM while it runs once,
// then replays it from the cache with the program counter frozen.
module jtdsp16_cache_ctrl #(
    parameter int DEPTH = 15,
    parameter int KW    = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    jtdsp16_cache_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        REPLAY = 2'd2
    } state_t;

    state_t        state_r;
    logic [3:0]    idx_r;
    logic [3:0]    stored_ni_r;
    logic [KW-1:0] rem_cnt_r;
    logic [15:0]   mem_r [0:DEPTH-1];
    logic [15:0]   cache_word_s;
    logic          last_s;

    assign last_s = (idx_r == (stored_ni_r - 4'd1));

    // Loop sequencer: state, body index, remaining passes and stored body length
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= 4'd0;
            rem_cnt_r   <= KW'(0);
            stored_ni_r <= 4'd0;
        end else if (cen) begin
            case (state_r)
                IDLE: begin
                    // DO has priority over REDO when both are decoded together
                    if (bus.do_start && (bus.ni != 4'd0)) begin
                        state_r     <= LOAD;
                        idx_r       <= 4'd0;
                        stored_ni_r <= bus.ni;
                        rem_cnt_r   <= (bus.k == KW'(0)) ? KW'(0) : (bus.k - KW'(1));
                    end else if (bus.redo_start && (stored_ni_r != 4'd0) && (bus.k != KW'(0))) begin
                        state_r   <= REPLAY;
                        idx_r     <= 4'd0;
                        rem_cnt_r <= bus.k;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (last_s) begin
                        idx_r   <= 4'd0;
                        state_r <= (rem_cnt_r == KW'(0)) ? IDLE : REPLAY;
                    end else begin
                        idx_r <= idx_r + 4'd1;
                    end
                end
                REPLAY: begin
                    if (last_s) begin
                        idx_r <= 4'd0;
                        // Counter saturates at zero; a pass count of one ends the loop
                        if (rem_cnt_r != KW'(0)) begin
                            rem_cnt_r <= rem_cnt_r - KW'(1);
                        end else begin
                            rem_cnt_r <= KW'(0);
                        end
                        if (rem_cnt_r <= KW'(1)) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= REPLAY;
                        end
                    end else begin
                        idx_r <= idx_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= 4'd0;
                end
            endcase
        end
    end

    // Body capture while loading; the array keeps its contents across reset for REDO
    always_ff @(posedge clk) begin
        if (cen && !rst && (state_r == LOAD)) begin
            mem_r[idx_r] <= bus.rom_dout;
        end
    end

    // Replay word selection; the bus reads zero whenever the cache is not the source
    always_comb begin
        cache_word_s = 16'h0000;
        if (state_r == REPLAY) begin
            cache_word_s = mem_r[idx_r];
        end else begin
            cache_word_s = 16'h0000;
        end
    end

    assign bus.cache_dout = cache_word_s;
    assign bus.cache_sel  = (state_r == REPLAY);
    assign bus.pc_hold    = (state_r == REPLAY);
    assign bus.busy       = (state_r != IDLE);
    assign bus.irq_mask   = (state_r != IDLE);
    assign bus.rem_cnt    = rem_cnt_r;
endmodule
